// File: rtl/pulse_cmd_if.sv
// Host-side byte stream, response handshake and pulse-generator control bundle.
// master = UART/host side, slave = pulse_cmd_ctrl.
interface pulse_cmd_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic [31:0] pulse_start;
   logic [31:0] pulse_end;
   logic        trig_out;
   logic        busy;
   logic        frame_err;

   modport master (
      output rx_data, rx_valid, tx_ready,
      input  tx_data, tx_valid, pulse_start, pulse_end, trig_out, busy, frame_err
   );

   modport slave (
      input  rx_data, rx_valid, tx_ready,
      output tx_data, tx_valid, pulse_start, pulse_end, trig_out, busy, frame_err
   );
endinterface

// File: rtl/pulse_cmd_ctrl.sv
// UART command parser for the single-pulse generator; ACK/NAK two cycles after the last frame byte.
// Response byte held until tx_ready, rx bytes dropped meanwhile. CHECKSUM_EN adds a trailing XOR byte.
module pulse_cmd_ctrl #(
   parameter logic [31:0] DEF_START   = 32'd1000,
   parameter logic [31:0] DEF_END     = 32'd2000,
   parameter int          TRIG_CYCLES = 8,
   parameter logic [31:0] TIMEOUT_CYC = 32'd5000000
) (
   input logic        clk,
   input logic        rst_n,
   pulse_cmd_if.slave bus
);

   localparam logic [7:0] SYNC_BYTE     = 8'hA5;
   localparam logic [7:0] ACK_BYTE      = 8'h55;
   localparam logic [7:0] NAK_BYTE      = 8'hEE;
   localparam logic [7:0] CMD_SET_START = 8'h01;
   localparam logic [7:0] CMD_SET_END   = 8'h02;
   localparam logic [7:0] CMD_FIRE      = 8'h03;
   localparam logic [7:0] CMD_ABORT     = 8'h04;
   localparam logic [7:0] TRIG_LAST     = 8'(TRIG_CYCLES - 1);
   localparam logic [31:0] TO_LAST      = TIMEOUT_CYC - 32'd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_DATA,
`ifdef CHECKSUM_EN
      S_CSUM,
`endif
      S_EXEC,
      S_RESP
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  byte_cnt;
   logic [7:0]  cmd_q;
   logic [31:0] shadow;
   logic [31:0] to_cnt;
   logic [7:0]  trig_cnt;
   logic        in_frame;
   logic        timeout_hit;
   logic        csum_bad;
   logic        fire_ok;

`ifdef CHECKSUM_EN
   logic [7:0] csum_calc;
   assign csum_calc = cmd_q ^ shadow[31:24] ^ shadow[23:16] ^ shadow[15:8] ^ shadow[7:0];
   assign csum_bad  = (state == S_CSUM) && bus.rx_valid && (bus.rx_data != csum_calc);
   assign in_frame  = (state == S_CMD) || (state == S_DATA) || (state == S_CSUM);
`else
   assign csum_bad  = 1'b0;
   assign in_frame  = (state == S_CMD) || (state == S_DATA);
`endif

   // A byte arriving on the terminal-count cycle wins over the timeout.
   assign timeout_hit = in_frame && !bus.rx_valid && (to_cnt == TO_LAST);
   assign fire_ok     = !bus.busy && (bus.pulse_end > bus.pulse_start);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) state_nxt = S_CMD;
         S_CMD: begin
            if (timeout_hit)       state_nxt = S_IDLE;
            else if (bus.rx_valid) state_nxt = S_DATA;
         end
         S_DATA: begin
            if (timeout_hit) state_nxt = S_IDLE;
`ifdef CHECKSUM_EN
            else if (bus.rx_valid && byte_cnt == 2'd3) state_nxt = S_CSUM;
         end
         S_CSUM: begin
            if (timeout_hit)       state_nxt = S_IDLE;
            else if (csum_bad)     state_nxt = S_RESP;
            else if (bus.rx_valid) state_nxt = S_EXEC;
`else
            else if (bus.rx_valid && byte_cnt == 2'd3) state_nxt = S_EXEC;
`endif
         end
         S_EXEC: state_nxt = S_RESP;
         S_RESP: if (bus.tx_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.pulse_start <= DEF_START;
         bus.pulse_end   <= DEF_END;
         bus.trig_out    <= 1'b0;
         bus.busy        <= 1'b0;
         bus.tx_valid    <= 1'b0;
         bus.tx_data     <= 8'h00;
         bus.frame_err   <= 1'b0;
         byte_cnt        <= 2'd0;
         cmd_q           <= 8'h00;
         shadow          <= 32'd0;
         to_cnt          <= 32'd0;
         trig_cnt        <= 8'd0;
      end else begin
         bus.frame_err <= timeout_hit | csum_bad;
         to_cnt        <= (in_frame && !bus.rx_valid && !timeout_hit) ? to_cnt + 32'd1 : 32'd0;

         if (state == S_IDLE && bus.rx_valid && bus.rx_data == SYNC_BYTE) byte_cnt <= 2'd0;
         if (state == S_CMD && bus.rx_valid) cmd_q <= bus.rx_data;
         if (state == S_DATA && bus.rx_valid) begin
            shadow   <= {shadow[23:0], bus.rx_data};
            byte_cnt <= byte_cnt + 2'd1;
         end

         // Trigger runs on its own; busy lingers one cycle past the falling edge.
         if (bus.trig_out) begin
            if (trig_cnt == TRIG_LAST) bus.trig_out <= 1'b0;
            else                       trig_cnt     <= trig_cnt + 8'd1;
         end else if (bus.busy) begin
            bus.busy <= 1'b0;
         end

         if (state == S_RESP && bus.tx_ready) bus.tx_valid <= 1'b0;

         if (csum_bad) begin
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= NAK_BYTE;
         end

         if (state == S_EXEC) begin
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= NAK_BYTE;
            case (cmd_q)
               CMD_SET_START: begin
                  bus.pulse_start <= shadow;
                  bus.tx_data     <= ACK_BYTE;
               end
               CMD_SET_END: begin
                  bus.pulse_end <= shadow;
                  bus.tx_data   <= ACK_BYTE;
               end
               CMD_FIRE: begin
                  if (fire_ok) begin
                     bus.busy     <= 1'b1;
                     bus.trig_out <= 1'b1;
                     trig_cnt     <= 8'd0;
                     bus.tx_data  <= ACK_BYTE;
                  end
               end
               CMD_ABORT: begin
                  bus.busy     <= 1'b0;
                  bus.trig_out <= 1'b0;
                  trig_cnt     <= 8'd0;
                  bus.tx_data  <= ACK_BYTE;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
